// File: rtl/answer_ctrl.sv
// Answering-round controller for the multichannel quiz machine.
// Picks up the game settings once setting is complete, then runs buzz-in arbitration, the
// per-answer countdown, host judging and per-player score keeping with lockout.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   is_set_over                settings valid; dropping it aborts to IDLE
//   num_people, count_seconds  player count (2..4) and answer window in seconds
//   correct_point, mistake_point  points added on right / subtracted on wrong or timeout
//   start_btn, buzz[3:0], judge_right, judge_wrong  debounced keys, act on rising edge
//   game_state                 0 IDLE, 1 READY, 2 ANSWER
//   winner                     one-hot current answerer (0 outside ANSWER)
//   time_left                  remaining seconds of the current answer
//   lockout                    players barred from buzzing this question
//   score0..score3             player scores
//   result_valid, result_ok    one-cycle resolution pulse and its verdict
module answer_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               is_set_over,
  input  logic [5:0]         num_people,
  input  logic [5:0]         count_seconds,
  input  logic [5:0]         correct_point,
  input  logic [5:0]         mistake_point,
  input  logic               start_btn,
  input  logic [3:0]         buzz,
  input  logic               judge_right,
  input  logic               judge_wrong,
  output logic [1:0]         game_state,
  output logic [3:0]         winner,
  output logic [5:0]         time_left,
  output logic [3:0]         lockout,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [SCORE_W-1:0] score3,
  output logic               result_valid,
  output logic               result_ok
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Wide enough to hold a score plus a 6-bit point value without overflow.
  localparam int unsigned ExtW = ((SCORE_W > 6) ? SCORE_W : 6) + 1;
  localparam logic [TickW-1:0]   TickMax  = TickW'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReady  = 2'd1,
    StAnswer = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic start_prev_q, right_prev_q, wrong_prev_q;
  logic [3:0] buzz_prev_q;
  logic [5:0] np_q, np_d, cs_q, cs_d, cp_q, cp_d, mp_q, mp_d;
  logic [3:0] winner_q, winner_d, lock_q, lock_d;
  logic [5:0] time_q, time_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [SCORE_W-1:0] score_q [4];
  logic [SCORE_W-1:0] score_d [4];
  logic rv_q, rv_d, ro_q, ro_d;

  logic start_ev, right_ev, wrong_ev;
  logic [3:0] buzz_ev, en_mask, eligible, pick, lock_wrong;
  logic [1:0] win_idx;
  logic [ExtW-1:0] cur_ext, add_ext;
  logic [SCORE_W-1:0] score_inc, score_dec;
  logic set_ok, wrap, timeout;

  assign start_ev = start_btn & ~start_prev_q;
  assign buzz_ev  = buzz & ~buzz_prev_q;
  assign right_ev = judge_right & ~right_prev_q;
  assign wrong_ev = judge_wrong & ~wrong_prev_q;
  assign set_ok   = (num_people >= 6'd2) && (num_people <= 6'd4) && (count_seconds != 6'd0);

  always_comb begin
    en_mask = '0;
    win_idx = '0;
    for (int i = 0; i < 4; i++) begin
      en_mask[i] = (np_q > 6'(i));
      if (winner_q[i]) win_idx = 2'(i);
    end
  end

  // Lowest eligible index wins: isolate the least-significant set bit.
  assign eligible = buzz_ev & en_mask & ~lock_q;
  assign pick     = eligible & (~eligible + 4'd1);

  assign cur_ext   = ExtW'(score_q[win_idx]);
  assign add_ext   = cur_ext + ExtW'(cp_q);
  assign score_inc = (add_ext > ExtW'(ScoreMax)) ? ScoreMax : add_ext[SCORE_W-1:0];
  assign score_dec = (ExtW'(mp_q) >= cur_ext) ? '0 : SCORE_W'(cur_ext - ExtW'(mp_q));

  // A question with every enabled player locked out starts over with nobody locked.
  always_comb begin
    lock_wrong = lock_q | winner_q;
    if ((lock_wrong & en_mask) == en_mask) lock_wrong = '0;
  end

  always_comb begin
    state_d  = state_q;
    np_d     = np_q;
    cs_d     = cs_q;
    cp_d     = cp_q;
    mp_d     = mp_q;
    winner_d = winner_q;
    time_d   = time_q;
    tick_d   = tick_q;
    lock_d   = lock_q;
    score_d  = score_q;
    rv_d     = 1'b0;
    ro_d     = 1'b0;
    wrap     = 1'b0;
    timeout  = 1'b0;

    if (!is_set_over) begin
      state_d  = StIdle;
      winner_d = '0;
      time_d   = '0;
    end else if (start_ev) begin
      np_d = num_people;
      cs_d = count_seconds;
      cp_d = correct_point;
      mp_d = mistake_point;
      // From IDLE only legal settings open a game; mid-game a start always restarts.
      if (state_q != StIdle || set_ok) begin
        state_d  = StReady;
        lock_d   = '0;
        winner_d = '0;
        time_d   = '0;
        for (int i = 0; i < 4; i++) score_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        StReady: begin
          if (pick != 4'd0) begin
            winner_d = pick;
            time_d   = cs_q;
            tick_d   = '0;
            state_d  = StAnswer;
          end
        end
        StAnswer: begin
          wrap    = (tick_q == TickMax);
          tick_d  = wrap ? '0 : tick_q + 1'b1;
          timeout = wrap && (time_q == 6'd1);
          if (wrap) time_d = time_q - 6'd1;
          if (right_ev && !wrong_ev) begin
            score_d[win_idx] = score_inc;
            lock_d   = '0;
            rv_d     = 1'b1;
            ro_d     = 1'b1;
            winner_d = '0;
            time_d   = '0;
            state_d  = StReady;
          end else if ((wrong_ev && !right_ev) || timeout) begin
            score_d[win_idx] = score_dec;
            lock_d   = lock_wrong;
            rv_d     = 1'b1;
            winner_d = '0;
            time_d   = '0;
            state_d  = StReady;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      buzz_prev_q  <= '0;
      right_prev_q <= 1'b0;
      wrong_prev_q <= 1'b0;
      np_q         <= '0;
      cs_q         <= '0;
      cp_q         <= '0;
      mp_q         <= '0;
      winner_q     <= '0;
      time_q       <= '0;
      tick_q       <= '0;
      lock_q       <= '0;
      rv_q         <= 1'b0;
      ro_q         <= 1'b0;
      for (int i = 0; i < 4; i++) score_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_btn;
      buzz_prev_q  <= buzz;
      right_prev_q <= judge_right;
      wrong_prev_q <= judge_wrong;
      np_q         <= np_d;
      cs_q         <= cs_d;
      cp_q         <= cp_d;
      mp_q         <= mp_d;
      winner_q     <= winner_d;
      time_q       <= time_d;
      tick_q       <= tick_d;
      lock_q       <= lock_d;
      rv_q         <= rv_d;
      ro_q         <= ro_d;
      for (int i = 0; i < 4; i++) score_q[i] <= score_d[i];
    end
  end

  assign game_state   = state_q;
  assign winner       = winner_q;
  assign time_left    = time_q;
  assign lockout      = lock_q;
  assign score0       = score_q[0];
  assign score1       = score_q[1];
  assign score2       = score_q[2];
  assign score3       = score_q[3];
  assign result_valid = rv_q;
  assign result_ok    = ro_q;

endmodule

// File: tb/tb_answer_ctrl.sv
// Self-checking bench for answer_ctrl: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the quiz rules.
module tb_answer_ctrl;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned ScoreW  = 8;
  localparam int          ScoreMx = (1 << ScoreW) - 1;

  logic        clk;
  logic        rst_n;
  logic        is_set_over;
  logic [5:0]  num_people, count_seconds, correct_point, mistake_point;
  logic        start_btn;
  logic [3:0]  buzz;
  logic        judge_right, judge_wrong;
  logic [1:0]  game_state;
  logic [3:0]  winner, lockout;
  logic [5:0]  time_left;
  logic [ScoreW-1:0] score0, score1, score2, score3;
  logic        result_valid, result_ok;

  answer_ctrl #(
    .TICK_DIV(TickDiv),
    .SCORE_W (ScoreW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .is_set_over  (is_set_over),
    .num_people   (num_people),
    .count_seconds(count_seconds),
    .correct_point(correct_point),
    .mistake_point(mistake_point),
    .start_btn    (start_btn),
    .buzz         (buzz),
    .judge_right  (judge_right),
    .judge_wrong  (judge_wrong),
    .game_state   (game_state),
    .winner       (winner),
    .time_left    (time_left),
    .lockout      (lockout),
    .score0       (score0),
    .score1       (score1),
    .score2       (score2),
    .score3       (score3),
    .result_valid (result_valid),
    .result_ok    (result_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: game phase (0 idle, 1 ready, 2 answering), answerer index (-1 none).
  int   m_st, m_win, m_tl, m_tick, m_np, m_cs, m_cp, m_mp;
  int   m_sc [4];
  bit   m_lock [4];
  bit   m_rv, m_ro;
  bit   p_start, p_right, p_wrong;
  bit   p_buzz [4];

  task automatic model_reset();
    m_st = 0; m_win = -1; m_tl = 0; m_tick = 0;
    m_np = 0; m_cs = 0; m_cp = 0; m_mp = 0;
    m_rv = 0; m_ro = 0;
    p_start = 0; p_right = 0; p_wrong = 0;
    for (int i = 0; i < 4; i++) begin
      m_sc[i] = 0; m_lock[i] = 0; p_buzz[i] = 0;
    end
  endtask

  task automatic resolve(input bit ok);
    int s;
    bit all_locked;
    s = m_sc[m_win];
    if (ok) begin
      m_sc[m_win] = (s + m_cp > ScoreMx) ? ScoreMx : s + m_cp;
      for (int i = 0; i < 4; i++) m_lock[i] = 0;
    end else begin
      m_sc[m_win] = (s - m_mp < 0) ? 0 : s - m_mp;
      m_lock[m_win] = 1;
      all_locked = 1;
      for (int i = 0; i < 4; i++) if (i < m_np && !m_lock[i]) all_locked = 0;
      if (all_locked) for (int i = 0; i < 4; i++) m_lock[i] = 0;
    end
    m_rv = 1; m_ro = ok;
    m_win = -1; m_tl = 0; m_st = 1;
  endtask

  task automatic model_step();
    bit sev, rev, wev, tout;
    bit bev [4];
    if (!rst_n) begin
      model_reset();
      return;
    end
    sev = start_btn && !p_start;
    rev = judge_right && !p_right;
    wev = judge_wrong && !p_wrong;
    for (int i = 0; i < 4; i++) begin
      bev[i] = buzz[i] && !p_buzz[i];
      p_buzz[i] = buzz[i];
    end
    p_start = start_btn; p_right = judge_right; p_wrong = judge_wrong;
    m_rv = 0; m_ro = 0;

    if (!is_set_over) begin
      m_st = 0; m_win = -1; m_tl = 0;
    end else if (sev) begin
      m_np = num_people; m_cs = count_seconds; m_cp = correct_point; m_mp = mistake_point;
      if (m_st != 0 || (m_np >= 2 && m_np <= 4 && m_cs != 0)) begin
        m_st = 1; m_win = -1; m_tl = 0;
        for (int i = 0; i < 4; i++) begin
          m_sc[i] = 0; m_lock[i] = 0;
        end
      end
    end else if (m_st == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (m_win < 0 && bev[i] && i < m_np && !m_lock[i]) m_win = i;
      end
      if (m_win >= 0) begin
        m_tl = m_cs; m_tick = 0; m_st = 2;
      end
    end else if (m_st == 2) begin
      tout = 0;
      m_tick++;
      if (m_tick == TickDiv) begin
        m_tick = 0;
        if (m_tl == 1) tout = 1;
        m_tl--;
      end
      if (rev && !wev) resolve(1);
      else if ((wev && !rev) || tout) resolve(0);
    end
  endtask

  task automatic compare_all();
    int lk;
    lk = 0;
    for (int i = 0; i < 4; i++) if (m_lock[i]) lk |= (1 << i);
    check("game_state", int'(game_state), m_st);
    check("winner", int'(winner), (m_win < 0) ? 0 : (1 << m_win));
    check("time_left", int'(time_left), m_tl);
    check("lockout", int'(lockout), lk);
    check("score0", int'(score0), m_sc[0]);
    check("score1", int'(score1), m_sc[1]);
    check("score2", int'(score2), m_sc[2]);
    check("score3", int'(score3), m_sc[3]);
    check("result_valid", int'(result_valid), int'(m_rv));
    check("result_ok", int'(result_ok), int'(m_ro));
  endtask

  // One clock: model advances on the edge, outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_start();
    start_btn = 1; step(); start_btn = 0; step();
  endtask

  task automatic press_buzz(input logic [3:0] m);
    buzz = m; step(); buzz = 4'd0; step();
  endtask

  task automatic press_right();
    judge_right = 1; step(); judge_right = 0; step();
  endtask

  task automatic press_wrong();
    judge_wrong = 1; step(); judge_wrong = 0; step();
  endtask

  task automatic settings(input int np, input int cs, input int cp, input int mp);
    num_people = 6'(np); count_seconds = 6'(cs); correct_point = 6'(cp); mistake_point = 6'(mp);
  endtask

  initial begin
    rst_n = 0; is_set_over = 0; start_btn = 0; buzz = 4'hF;
    judge_right = 0; judge_wrong = 0;
    settings(0, 0, 0, 0);
    model_reset();
    repeat (3) step();
    rst_n = 1;
    repeat (3) step();
    check("idle_after_reset", int'(game_state), 0);
    buzz = 4'd0;
    step();

    // Game with 3 players, 2 s window.
    is_set_over = 1;
    settings(3, 2, 5, 3);
    step();
    pulse_start();
    check("ready_after_start", int'(game_state), 1);
    buzz = 4'b0110; step();
    check("buzz_lowest_wins", int'(winner), 2);
    check("time_loaded", int'(time_left), 2);
    buzz = 4'd0; step();
    judge_right = 1; step();
    check("right_pulse", int'(result_valid), 1);
    check("right_score1", int'(score1), 5);
    judge_right = 0; step();
    check("pulse_one_cycle", int'(result_valid), 0);

    // Timeout floors the score and locks player 0 out.
    settings(3, 2, 1, 3);
    pulse_start();
    press_buzz(4'b0001);
    press_right();
    check("score0_one", int'(score0), 1);
    press_buzz(4'b0001);
    repeat (2 * TickDiv) step();
    check("timeout_floor", int'(score0), 0);
    check("timeout_lock", int'(lockout), 1);
    press_buzz(4'b0001);
    check("locked_buzz_ignored", int'(game_state), 1);

    // Two players both wrong -> lockout clears; player 3 never enabled.
    settings(2, 2, 4, 1);
    pulse_start();
    press_buzz(4'b0001);
    press_wrong();
    press_buzz(4'b0010);
    press_wrong();
    check("lock_all_clears", int'(lockout), 0);
    press_buzz(4'b1000);
    check("p3_ignored", int'(game_state), 1);

    // Abort, illegal start, abort mid-answer.
    is_set_over = 0; step();
    is_set_over = 1;
    settings(5, 2, 1, 3);
    pulse_start();
    check("np5_stays_idle", int'(game_state), 0);
    settings(3, 2, 1, 3);
    pulse_start();
    press_buzz(4'b0100);
    press_right();
    press_buzz(4'b0100);
    is_set_over = 0; step();
    check("abort_idle", int'(game_state), 0);
    check("abort_keeps_score", int'(score2), 1);
    is_set_over = 1; step();

    // Saturation and simultaneous judge keys.
    settings(2, 3, 10, 2);
    pulse_start();
    for (int k = 0; k < 26; k++) begin
      press_buzz(4'b0001);
      press_right();
    end
    check("saturate", int'(score0), 255);
    press_buzz(4'b0001);
    judge_right = 1; judge_wrong = 1; step();
    judge_right = 0; judge_wrong = 0; step();
    check("both_judges_ignored", int'(game_state), 2);
    press_right();

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      is_set_over = ($urandom_range(0, 149) != 0);
      start_btn   = ($urandom_range(0, 79) == 0);
      buzz        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      judge_right = ($urandom_range(0, 11) == 0);
      judge_wrong = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 49) == 0)
        settings($urandom_range(0, 6), $urandom_range(1, 3), $urandom_range(0, 63),
                 $urandom_range(0, 63));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/answer_ctrl.md
Name: answer_ctrl

Overview:
- Consumer side of the quiz-machine settings interface: reads the latched game settings (player count, answer time, correct/mistake points) once setting is complete.
- Runs the answering rounds: buzz-in arbitration, per-answer countdown, host judging, per-player score keeping with lockout.
- Sits between the setting stage and the display/speaker stage of the multichannel answering machine.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per countdown second (set small in simulation).
- SCORE_W, 8, width of each player score.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- is_set_over  in  1  level; 1 = settings valid and stable
- num_people  in  6  player count; legal 2..4
- count_seconds  in  6  answer window in seconds; legal >=1
- correct_point  in  6  points added on correct answer
- mistake_point  in  6  points subtracted on wrong answer or timeout
- start_btn  in  1  debounced, synchronous level; acts on rising edge
- buzz  in  4  debounced player buttons; bit i = player i; acts on rising edge
- judge_right  in  1  host key, rising edge
- judge_wrong  in  1  host key, rising edge
- game_state  out  2  0 IDLE, 1 READY, 2 ANSWER
- winner  out  4  one-hot current answerer; 0 outside ANSWER
- time_left  out  6  remaining seconds in ANSWER; 0 otherwise
- lockout  out  4  players barred from buzzing this question
- score0..score3  out  SCORE_W each  player scores
- result_valid  out  1  1-cycle pulse when an answer is resolved
- result_ok  out  1  valid with result_valid: 1 right, 0 wrong/timeout

Behaviour:
- Reset (async, rst_n=0): every output and internal register is 0; state IDLE; edge-detect history is 0, so an input held high through reset does not fire on release.
- Edge detect: each button is registered once; event = cur & ~prev. One event per press.
- Global abort: is_set_over=0 in any state -> IDLE next cycle. Scores and lockout hold; winner and time_left clear.
- IDLE: on a start event with is_set_over=1:
  - Latch all four settings into internal copies; later input changes are ignored until the next start.
  - If latched num_people is outside 2..4 or count_seconds=0, stay IDLE.
  - Otherwise clear all scores and lockout, then go to READY.
- READY:
  - Eligible players are i < num_people and lockout[i]=0.
  - On a buzz event from any eligible player, the lowest index wins.
  - Set winner one-hot, load time_left=count_seconds, reset the tick counter, and go to ANSWER.
  - Buzzes from ineligible players are ignored.
- ANSWER:
  - Tick counter counts 0..TICK_DIV-1. On wrap, time_left decrements.
  - A wrap with time_left=1 is a timeout: time_left becomes 0.
  - judge_right: add correct_point to the winner's score, saturating at 2^SCORE_W-1. Clear lockout.
  - judge_wrong or timeout: subtract mistake_point, flooring at 0. Set lockout[winner].
  - If lockout then covers all enabled players, clear lockout instead.
  - Any resolution: pulse result_valid with result_ok for 1 cycle, clear winner and time_left, and return to READY the next cycle.
  - Priority: judge beats timeout in the same cycle. judge_right and judge_wrong together are ignored. Buzz events are ignored.
- Start event in READY/ANSWER: re-latch settings, clear scores and lockout, go to READY (new game).
- Latency: any event to registered outputs is exactly 1 cycle.

Test Plan:
- Reset with buzz=4'b1111 held, release rst_n -> all outputs 0, no READY entry. Start with is_set_over=1, num_people=3, count_seconds=2 -> game_state=1, scores 0.
- READY, buzz=4'b0110 in one cycle -> winner=4'b0010, time_left=2. Then judge_right with correct_point=5 -> score1=5, result_valid=1 and result_ok=1 for one cycle, game_state=1.
- Player 0 wins the buzz, mistake_point=3, score0=1, no judge for 2*TICK_DIV cycles -> time_left goes 2,1,0; score0=0 (floored); lockout=4'b0001; a later buzz[0] is ignored.
- num_people=2, player 0 answers wrong, then player 1 answers wrong -> lockout returns to 0. Buzz on player 3 is always ignored.
- Start with num_people=5 -> stays IDLE. Drop is_set_over mid-ANSWER -> IDLE next cycle, scores retained.
- score=250, correct_point=10 -> score=255. judge_right and judge_wrong in the same cycle -> no change.
